burst_pattern_ctrl: RTL and testbench

Sequences test-pattern bursts into a downstream FIFO for link/DAQ bring-up on the user side of the design.
Software or top-level logic loads the burst length, burst count, inter-burst gap and start value, then pulses START.
The block issues the programmed number of incrementing 32-bit words, honours FIFO_FULL backpressure, inserts idle gaps between bursts, and reports completion.
It replaces free-running fixed-count generators with a restartable, configurable sequencer.

---
 rtl/burst_pattern_pkg.sv | 16 +
 rtl/cycle_down_counter.sv | 29 ++
 rtl/burst_pattern_ctrl.sv | 146 ++++++++++++++
 tb/tb_burst_pattern_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pattern_pkg.sv
// Shared state encoding and default widths for the burst pattern sequencer.
package burst_pattern_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;
    localparam int GAP_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with enable; is_one flags the final count so the
// owner can act on the same edge that consumes it.
module cycle_down_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         is_one
);

    logic [W-1:0] count;

    // Load wins over enable; the count parks at zero instead of wrapping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign is_one = (count == W'(1));

endmodule

// File: rtl/burst_pattern_ctrl.sv
// Restartable test-pattern burst sequencer feeding a downstream FIFO with
// incrementing words, backpressure, inter-burst gaps and abort.
module burst_pattern_ctrl
    import burst_pattern_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GAP_W  = GAP_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [LEN_W-1:0]  BURST_LEN,
    input  logic [CNT_W-1:0]  NUM_BURSTS,
    input  logic [GAP_W-1:0]  GAP_CYC,
    input  logic [DATA_W-1:0] SEED,
    input  logic              FIFO_FULL,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              WR_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic [31:0]       WORD_CNT
);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [GAP_W-1:0] gap_q;

    logic             start_ok;
    logic             last_word;
    logic             more_bursts;
    logic             gap_end;
    logic             gap_en;
    logic             word_load;
    logic             gap_load;
    logic [LEN_W-1:0] word_load_val;
    logic             word_one;
    logic             burst_one;
    logic             gap_one;

    assign start_ok      = (state == ST_IDLE) && START && !ABORT;
    assign WR_EN         = (state == ST_BURST) && !FIFO_FULL && !ABORT;
    assign last_word     = WR_EN && word_one;
    assign more_bursts   = last_word && !burst_one;
    assign gap_en        = (state == ST_GAP);
    assign gap_end       = gap_en && !ABORT && gap_one;
    assign word_load     = start_ok || gap_end || (more_bursts && (gap_q == '0));
    assign word_load_val = start_ok ? BURST_LEN : len_q;
    assign gap_load      = more_bursts && (gap_q != '0);

    cycle_down_counter #(.W(LEN_W)) u_word_ctr (
        .CLK      (CLK),
        .RST      (RST),
        .load     (word_load),
        .load_val (word_load_val),
        .en       (WR_EN),
        .is_one   (word_one)
    );

    cycle_down_counter #(.W(CNT_W)) u_burst_ctr (
        .CLK      (CLK),
        .RST      (RST),
        .load     (start_ok),
        .load_val (NUM_BURSTS),
        .en       (last_word),
        .is_one   (burst_one)
    );

    cycle_down_counter #(.W(GAP_W)) u_gap_ctr (
        .CLK      (CLK),
        .RST      (RST),
        .load     (gap_load),
        .load_val (gap_q),
        .en       (gap_en),
        .is_one   (gap_one)
    );

    // BUSY and DONE are registered from the next state so they line up with
    // the state they describe; abort drops straight to IDLE without DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            DATA_OUT <= '0;
            WORD_CNT <= '0;
            DONE     <= 1'b0;
            BUSY     <= 1'b0;
            len_q    <= '0;
            gap_q    <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q    <= BURST_LEN;
                        gap_q    <= GAP_CYC;
                        DATA_OUT <= SEED;
                        WORD_CNT <= '0;
                        if ((BURST_LEN == '0) || (NUM_BURSTS == '0)) begin
                            state <= ST_FINISH;
                            DONE  <= 1'b1;
                        end else begin
                            state <= ST_BURST;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (ABORT) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (WR_EN) begin
                        DATA_OUT <= DATA_OUT + DATA_W'(1);
                        WORD_CNT <= WORD_CNT + 32'd1;
                        if (last_word) begin
                            if (burst_one) begin
                                state <= ST_FINISH;
                                DONE  <= 1'b1;
                                BUSY  <= 1'b0;
                            end else if (gap_q != '0) begin
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (ABORT) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (gap_one) begin
                        state <= ST_BURST;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_pattern_ctrl.sv
// Self-checking bench for burst_pattern_ctrl: directed and randomized runs
// compared against a phase-level model of the expected write timeline.
module tb_burst_pattern_ctrl;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              START;
    logic              ABORT;
    logic [LEN_W-1:0]  BURST_LEN;
    logic [CNT_W-1:0]  NUM_BURSTS;
    logic [GAP_W-1:0]  GAP_CYC;
    logic [DATA_W-1:0] SEED;
    logic              FIFO_FULL;
    logic [DATA_W-1:0] DATA_OUT;
    logic              WR_EN;
    logic              BUSY;
    logic              DONE;
    logic [31:0]       WORD_CNT;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          full_q[$];
    bit          ew[$];
    bit          wr_tr[$];
    bit          done_tr[$];
    bit          busy_tr[$];
    logic [31:0] obs_q[$];

    always #5 CLK = ~CLK;

    burst_pattern_ctrl #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W),
        .GAP_W  (GAP_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .ABORT      (ABORT),
        .BURST_LEN  (BURST_LEN),
        .NUM_BURSTS (NUM_BURSTS),
        .GAP_CYC    (GAP_CYC),
        .SEED       (SEED),
        .FIFO_FULL  (FIFO_FULL),
        .DATA_OUT   (DATA_OUT),
        .WR_EN      (WR_EN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .WORD_CNT   (WORD_CNT)
    );

    // Expected write/idle timeline starting the cycle after START: each burst
    // needs len non-full cycles, each gap is exactly gap cycles.
    task automatic build_expected(input int len, input int nb, input int gap);
        int pos;
        int left;
        bit f;
        pos = 0;
        ew.delete();
        if (len == 0 || nb == 0) return;
        for (int b = 0; b < nb; b++) begin
            left = len;
            while (left > 0) begin
                f = (pos < full_q.size()) ? full_q[pos] : 1'b0;
                ew.push_back(!f);
                if (!f) left--;
                pos++;
            end
            if (b < nb - 1) begin
                for (int g = 0; g < gap; g++) begin
                    ew.push_back(1'b0);
                    pos++;
                end
            end
        end
    endtask

    task automatic pulse_start(input int len, input int nb, input int gap, input logic [31:0] seed);
        BURST_LEN  = LEN_W'(len);
        NUM_BURSTS = CNT_W'(nb);
        GAP_CYC    = GAP_W'(gap);
        SEED       = seed;
        START      = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        START      = 1'b0;
        BURST_LEN  = LEN_W'($urandom);
        NUM_BURSTS = CNT_W'($urandom);
        GAP_CYC    = GAP_W'($urandom);
        SEED       = $urandom;
    endtask

    task automatic capture(input int ncyc);
        wr_tr.delete();
        done_tr.delete();
        busy_tr.delete();
        obs_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            FIFO_FULL = (i < full_q.size()) ? full_q[i] : 1'b0;
            @(negedge CLK);
            wr_tr.push_back(WR_EN);
            done_tr.push_back(DONE);
            busy_tr.push_back(BUSY);
            if (WR_EN) obs_q.push_back(DATA_OUT);
            @(posedge CLK);
            #1;
        end
        FIFO_FULL = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_cmp++; if (DATA_OUT !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data got %h want 0", DATA_OUT); end
        n_cmp++; if (WORD_CNT !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_wcnt got %h want 0", WORD_CNT); end
        n_cmp++; if (WR_EN !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wren got %b want 0", WR_EN); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", DONE); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_pattern_runs();
        int len, nb, gap, n_wr, ncyc;
        logic [31:0] seed, exp_d;
        bit exp_wr, exp_done, exp_busy;
        string name;
        for (int t = 0; t < 11; t++) begin
            full_q.delete();
            case (t)
                0: begin name = "basic";     len = 4; nb = 2; gap = 3; seed = 32'h10; end
                1: begin name = "backpress"; len = 4; nb = 2; gap = 3; seed = 32'h10;
                         for (int i = 0; i < 5; i++) full_q.push_back(i >= 2); end
                2: begin name = "zgap_wrap"; len = 2; nb = 3; gap = 0; seed = 32'hFFFF_FFFE; end
                3: begin name = "len_zero";  len = 0; nb = 5; gap = 2; seed = 32'h1234; end
                4: begin name = "nb_zero";   len = 3; nb = 0; gap = 1; seed = 32'h4321; end
                default: begin
                    name = "random";
                    len  = $urandom_range(1, 6);
                    nb   = $urandom_range(1, 4);
                    gap  = $urandom_range(0, 4);
                    seed = $urandom;
                    for (int i = 0; i < 60; i++) full_q.push_back($urandom_range(0, 9) < 3);
                end
            endcase
            build_expected(len, nb, gap);
            n_wr = (len == 0 || nb == 0) ? 0 : len * nb;
            ncyc = ew.size() + 2;
            pulse_start(len, nb, gap, seed);
            capture(ncyc);
            for (int i = 0; i < ncyc; i++) begin
                exp_wr   = (i < ew.size()) ? ew[i] : 1'b0;
                exp_done = (i == ew.size());
                exp_busy = (i < ew.size());
                n_cmp++;
                if (wr_tr[i] !== exp_wr || done_tr[i] !== exp_done || busy_tr[i] !== exp_busy) begin
                    n_fail++;
                    $display("[TB] FAIL %s_t%0d cycle %0d wr/done/busy got %b%b%b want %b%b%b",
                             name, t, i, wr_tr[i], done_tr[i], busy_tr[i], exp_wr, exp_done, exp_busy);
                end
            end
            n_cmp++;
            if (obs_q.size() != n_wr) begin
                n_fail++;
                $display("[TB] FAIL %s_t%0d write_count got %0d want %0d", name, t, obs_q.size(), n_wr);
            end
            for (int k = 0; k < obs_q.size() && k < n_wr; k++) begin
                exp_d = seed + 32'(k);
                n_cmp++;
                if (obs_q[k] !== exp_d) begin
                    n_fail++;
                    $display("[TB] FAIL %s_t%0d data[%0d] got %h want %h", name, t, k, obs_q[k], exp_d);
                end
            end
            n_cmp++;
            if (WORD_CNT !== 32'(n_wr)) begin
                n_fail++;
                $display("[TB] FAIL %s_t%0d word_cnt got %0d want %0d", name, t, WORD_CNT, n_wr);
            end
        end
    endtask

    task automatic test_abort();
        int nw, nd, nbusy;
        bit bad;
        full_q.delete();
        pulse_start(100, 1, 0, 32'h1000);
        nw  = 0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            START = (i == 5);
            SEED  = 32'hDEAD_0000;
            @(negedge CLK);
            if (WR_EN) begin
                if (DATA_OUT !== 32'h1000 + 32'(nw)) bad = 1'b1;
                nw++;
            end
            @(posedge CLK);
            #1;
        end
        START = 1'b0;
        n_cmp++; if (nw != 10 || bad) begin n_fail++; $display("[TB] FAIL abort_prefix writes got %0d (bad=%0d) want 10 (bad=0)", nw, bad); end
        ABORT = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        n_cmp++; if (WR_EN !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_wren got %b want 0", WR_EN); end
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy got %b want 0", BUSY); end
        n_cmp++; if (WORD_CNT !== 32'd10) begin n_fail++; $display("[TB] FAIL abort_wcnt got %0d want 10", WORD_CNT); end
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            if (DONE) nd++;
            @(negedge CLK);
        end
        n_cmp++; if (nd != 0) begin n_fail++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", nd); end
        @(posedge CLK);
        #1;
        ABORT = 1'b1;
        START = 1'b1;
        BURST_LEN  = LEN_W'(3);
        NUM_BURSTS = CNT_W'(1);
        @(posedge CLK);
        #1;
        ABORT = 1'b0;
        START = 1'b0;
        nw    = 0;
        nbusy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (WR_EN) nw++;
            if (BUSY) nbusy++;
        end
        n_cmp++; if (nw != 0 || nbusy != 0) begin n_fail++; $display("[TB] FAIL idle_start_abort writes/busy got %0d/%0d want 0/0", nw, nbusy); end
        @(posedge CLK);
        #1;
        pulse_start(2, 1, 0, 32'h55);
        capture(4);
        n_cmp++; if (obs_q.size() != 2) begin n_fail++; $display("[TB] FAIL post_abort_count got %0d want 2", obs_q.size()); end
        else begin
            n_cmp++; if (obs_q[0] !== 32'h55 || obs_q[1] !== 32'h56) begin n_fail++; $display("[TB] FAIL post_abort_data got %h,%h want 55,56", obs_q[0], obs_q[1]); end
        end
        n_cmp++; if (done_tr[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL post_abort_done got %b want 1", done_tr[2]); end
    endtask

    task automatic test_back_to_back();
        full_q.delete();
        pulse_start(1, 1, 0, 32'h200);
        @(negedge CLK);
        n_cmp++; if (WR_EN !== 1'b1 || DATA_OUT !== 32'h200) begin n_fail++; $display("[TB] FAIL b2b_first wr/data got %b/%h want 1/200", WR_EN, DATA_OUT); end
        @(posedge CLK);
        #1;
        @(negedge CLK);
        n_cmp++; if (DONE !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done got %b want 1", DONE); end
        @(posedge CLK);
        #1;
        pulse_start(1, 1, 0, 32'h300);
        @(negedge CLK);
        n_cmp++; if (WORD_CNT !== 32'd0) begin n_fail++; $display("[TB] FAIL b2b_wcnt_clear got %0d want 0", WORD_CNT); end
        n_cmp++; if (WR_EN !== 1'b1 || DATA_OUT !== 32'h300) begin n_fail++; $display("[TB] FAIL b2b_second wr/data got %b/%h want 1/300", WR_EN, DATA_OUT); end
        @(posedge CLK);
        #1;
        @(negedge CLK);
        n_cmp++; if (DONE !== 1'b1 || WORD_CNT !== 32'd1) begin n_fail++; $display("[TB] FAIL b2b_second_done done/wcnt got %b/%0d want 1/1", DONE, WORD_CNT); end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_async_reset();
        logic [31:0] exp_d;
        full_q.delete();
        pulse_start(50, 1, 0, 32'h77);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
        end
        #2;
        RST = 1'b1;
        #1;
        n_cmp++; if (WR_EN !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_wren got %b want 0", WR_EN); end
        n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_busy got %b want 0", BUSY); end
        n_cmp++; if (DATA_OUT !== 32'h0) begin n_fail++; $display("[TB] FAIL arst_data got %h want 0", DATA_OUT); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        build_expected(3, 2, 1);
        pulse_start(3, 2, 1, 32'hA0);
        capture(ew.size() + 2);
        n_cmp++; if (obs_q.size() != 6) begin n_fail++; $display("[TB] FAIL arst_rerun_count got %0d want 6", obs_q.size()); end
        for (int k = 0; k < obs_q.size() && k < 6; k++) begin
            exp_d = 32'hA0 + 32'(k);
            n_cmp++; if (obs_q[k] !== exp_d) begin n_fail++; $display("[TB] FAIL arst_rerun_data[%0d] got %h want %h", k, obs_q[k], exp_d); end
        end
        n_cmp++; if (done_tr[ew.size()] !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_rerun_done got %b want 1", done_tr[ew.size()]); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST        = 1'b1;
        START      = 1'b0;
        ABORT      = 1'b0;
        FIFO_FULL  = 1'b0;
        BURST_LEN  = '0;
        NUM_BURSTS = '0;
        GAP_CYC    = '0;
        SEED       = '0;
        $display("[TB] starting burst_pattern_ctrl bench");
        test_reset();
        test_pattern_runs();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
